bip_control: RTL

//  Control unit for the BIP accumulator CPU. Sequences fetch/execute and drives the accumulator datapath's select/write/op controls.
//  It fetches 16-bit instructions from a synchronous-read program memory.
//  It decodes each instruction into datapath controls and data-memory strobes.

---
 rtl/bip_pkg.sv | 25 ++
 rtl/bip_pc.sv | 20 ++
 rtl/bip_control.sv | 122 ++++++++++++
 3 files changed

// File: rtl/bip_pkg.sv
// Shared encodings for the BIP control unit: opcodes, accumulator source selects
// and the fetch/execute state machine states.
package bip_pkg;

  localparam logic [4:0] OPC_HLT  = 5'b00000;
  localparam logic [4:0] OPC_STO  = 5'b00001;
  localparam logic [4:0] OPC_LD   = 5'b00010;
  localparam logic [4:0] OPC_LDI  = 5'b00011;
  localparam logic [4:0] OPC_ADD  = 5'b00100;
  localparam logic [4:0] OPC_ADDI = 5'b00101;
  localparam logic [4:0] OPC_SUB  = 5'b00110;
  localparam logic [4:0] OPC_SUBI = 5'b00111;

  localparam logic [1:0] SETA_MEM = 2'b00;
  localparam logic [1:0] SETA_IMM = 2'b01;
  localparam logic [1:0] SETA_ALU = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/bip_pc.sv
// Program counter: advances by one when enabled, wraps silently at the top of the
// address space, cleared by the synchronous active-low reset.
module bip_pc #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= '0;
    end else if (en) begin
      pc <= pc + W'(1);
    end
  end

endmodule

// File: rtl/bip_control.sv
// BIP accumulator CPU control unit: two-cycle fetch/execute sequencer, instruction
// decoder driving the datapath controls, PC ownership, sticky halt and cycle counter.
module bip_control
  import bip_pkg::*;
#(
  parameter int PC_WIDTH  = 11,
  parameter int OPC_WIDTH = 5,
  parameter int CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [OPC_WIDTH+PC_WIDTH-1:0] Instr,
  output logic [PC_WIDTH-1:0]           Addr_Prog,
  output logic [PC_WIDTH-1:0]           Addr_Data,
  output logic [PC_WIDTH-1:0]           Data,
  output logic [1:0]                    SetA,
  output logic                          SetB,
  output logic                          Op,
  output logic                          WrAcc,
  output logic                          WrRam,
  output logic                          RdRam,
  output logic                          halted,
  output logic [CNT_WIDTH-1:0]          cycle_count,
  output state_t                        state
);

  localparam int IW = OPC_WIDTH + PC_WIDTH;

  state_t               state_q;
  logic [OPC_WIDTH-1:0] opc;
  logic [PC_WIDTH-1:0]  operand;
  logic                 is_hlt;
  logic                 exec_live;
  logic                 pc_en;

  assign opc     = Instr[IW-1 -: OPC_WIDTH];
  assign operand = Instr[PC_WIDTH-1:0];
  assign is_hlt  = (opc == OPC_WIDTH'(OPC_HLT));
  // A reset arriving during EXEC must suppress that cycle's strobes, not just the next state.
  assign exec_live = (state_q == EXEC) && reset;
  assign pc_en     = (state_q == EXEC) && !is_hlt;

  assign state  = state_q;
  assign halted = (state_q == HALT);

  bip_pc #(.W(PC_WIDTH)) u_pc (
    .clk   (clk),
    .reset (reset),
    .en    (pc_en),
    .pc    (Addr_Prog)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cycle_count <= '0;
    end else begin
      case (state_q)
        IDLE:    if (start) state_q <= FETCH;
        FETCH:   state_q <= EXEC;
        EXEC:    state_q <= is_hlt ? HALT : FETCH;
        default: state_q <= HALT;
      endcase
      // Counts only active fetch/execute cycles and saturates instead of wrapping.
      if ((state_q == FETCH || state_q == EXEC) && cycle_count != '1) begin
        cycle_count <= cycle_count + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    Addr_Data = '0;
    Data      = '0;
    SetA      = SETA_MEM;
    SetB      = 1'b0;
    Op        = 1'b0;
    WrAcc     = 1'b0;
    WrRam     = 1'b0;
    RdRam     = 1'b0;
    if (exec_live) begin
      Addr_Data = operand;
      Data      = operand;
      case (opc)
        OPC_WIDTH'(OPC_STO): WrRam = 1'b1;
        OPC_WIDTH'(OPC_LD): begin
          RdRam = 1'b1;
          SetA  = SETA_MEM;
          WrAcc = 1'b1;
        end
        OPC_WIDTH'(OPC_LDI): begin
          SetA  = SETA_IMM;
          WrAcc = 1'b1;
        end
        OPC_WIDTH'(OPC_ADD): begin
          RdRam = 1'b1;
          Op    = 1'b1;
          SetA  = SETA_ALU;
          WrAcc = 1'b1;
        end
        OPC_WIDTH'(OPC_ADDI): begin
          SetB  = 1'b1;
          Op    = 1'b1;
          SetA  = SETA_ALU;
          WrAcc = 1'b1;
        end
        OPC_WIDTH'(OPC_SUB): begin
          RdRam = 1'b1;
          SetA  = SETA_ALU;
          WrAcc = 1'b1;
        end
        OPC_WIDTH'(OPC_SUBI): begin
          SetB  = 1'b1;
          SetA  = SETA_ALU;
          WrAcc = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
